// File: rtl/eth_rx_block_lock.sv
// 64b/66b receive block-lock controller: hunts for sync-header alignment with
// bitslip requests, holds lock across header-error windows and flags high BER.
module eth_rx_block_lock #(
   parameter int SH_CNT_MAX   = 64,
   parameter int SH_INVLD_MAX = 16,
   parameter int SLIP_WAIT    = 32,
   parameter int BER_WINDOW   = 50000,
   parameter int BER_THRESH   = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_header,
   input  logic        i_header_valid,
   input  logic        i_data_valid,
   output logic        o_bitslip,
   output logic        o_block_lock,
   output logic        o_hi_ber,
   output logic        o_rx_data_valid,
   output logic        o_rx_header_valid,
   output logic [15:0] o_slip_count
);

   localparam int SH_CNT_W   = $clog2(SH_CNT_MAX + 1);
   localparam int SH_INVLD_W = $clog2(SH_INVLD_MAX + 1);
   localparam int WAIT_W     = $clog2(SLIP_WAIT + 1);
   localparam int BER_CYC_W  = $clog2(BER_WINDOW + 1);
   localparam int BER_INV_W  = $clog2(BER_THRESH + 1);

   localparam logic [SH_CNT_W-1:0]   SH_CNT_MAX_C   = SH_CNT_W'(SH_CNT_MAX);
   localparam logic [SH_CNT_W-1:0]   SH_CNT_ONE_C   = SH_CNT_W'(1);
   localparam logic [SH_INVLD_W-1:0] SH_INVLD_MAX_C = SH_INVLD_W'(SH_INVLD_MAX);
   localparam logic [SH_INVLD_W-1:0] SH_INVLD_ONE_C = SH_INVLD_W'(1);
   localparam logic [WAIT_W-1:0]     WAIT_LAST_C    = WAIT_W'(SLIP_WAIT - 1);
   localparam logic [WAIT_W-1:0]     WAIT_ONE_C     = WAIT_W'(1);
   localparam logic [BER_CYC_W-1:0]  BER_LAST_C     = BER_CYC_W'(BER_WINDOW - 1);
   localparam logic [BER_CYC_W-1:0]  BER_CYC_ONE_C  = BER_CYC_W'(1);
   localparam logic [BER_INV_W-1:0]  BER_THRESH_C   = BER_INV_W'(BER_THRESH);
   localparam logic [BER_INV_W-1:0]  BER_INV_ONE_C  = BER_INV_W'(1);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_TEST = 2'd1;
   localparam logic [1:0] ST_SLIP = 2'd2;
   localparam logic [1:0] ST_WAIT = 2'd3;

   // Only 01 and 10 are legal 64b/66b sync headers.
   function automatic logic header_ok(input logic [1:0] hdr);
      return hdr[1] ^ hdr[0];
   endfunction

   logic [1:0]            state_r, state_nxt_s;
   logic [SH_CNT_W-1:0]   sh_cnt_r, sh_cnt_nxt_s, sh_cnt_inc_s;
   logic [SH_INVLD_W-1:0] sh_invld_r, sh_invld_nxt_s, sh_invld_inc_s;
   logic [WAIT_W-1:0]     wait_r, wait_nxt_s;
   logic                  lock_r, lock_nxt_s, lock_clr_s;
   logic                  bitslip_r;
   logic [15:0]           slip_cnt_r;
   logic [BER_CYC_W-1:0]  ber_cyc_r;
   logic [BER_INV_W-1:0]  ber_inv_r, ber_inv_inc_s;
   logic                  hi_ber_r;
   logic                  sample_s, bad_s;

   assign sample_s       = i_data_valid & i_header_valid;
   assign bad_s          = sample_s & ~header_ok(i_header);
   assign sh_cnt_inc_s   = sh_cnt_r + SH_CNT_ONE_C;
   assign sh_invld_inc_s = bad_s ? (sh_invld_r + SH_INVLD_ONE_C) : sh_invld_r;
   assign ber_inv_inc_s  = (bad_s && (ber_inv_r != BER_THRESH_C)) ? (ber_inv_r + BER_INV_ONE_C)
                                                                  : ber_inv_r;

   // Lock FSM next-state; the invalid-count check outranks window completion.
   always_comb begin
      state_nxt_s    = state_r;
      sh_cnt_nxt_s   = sh_cnt_r;
      sh_invld_nxt_s = sh_invld_r;
      wait_nxt_s     = wait_r;
      lock_nxt_s     = lock_r;
      lock_clr_s     = 1'b0;
      case (state_r)
         ST_INIT: begin
            sh_cnt_nxt_s   = '0;
            sh_invld_nxt_s = '0;
            wait_nxt_s     = '0;
            state_nxt_s    = ST_TEST;
         end
         ST_TEST: begin
            if (sample_s) begin
               sh_cnt_nxt_s   = sh_cnt_inc_s;
               sh_invld_nxt_s = sh_invld_inc_s;
               if (lock_r) begin
                  if (sh_invld_inc_s == SH_INVLD_MAX_C) begin
                     lock_nxt_s  = 1'b0;
                     lock_clr_s  = 1'b1;
                     state_nxt_s = ST_SLIP;
                  end else if (sh_cnt_inc_s == SH_CNT_MAX_C) begin
                     state_nxt_s = ST_INIT;
                  end else begin
                     state_nxt_s = ST_TEST;
                  end
               end else begin
                  if (bad_s) begin
                     state_nxt_s = ST_SLIP;
                  end else if (sh_cnt_inc_s == SH_CNT_MAX_C) begin
                     lock_nxt_s  = 1'b1;
                     state_nxt_s = ST_INIT;
                  end else begin
                     state_nxt_s = ST_TEST;
                  end
               end
            end else begin
               state_nxt_s = ST_TEST;
            end
         end
         ST_SLIP: begin
            wait_nxt_s  = '0;
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_r == WAIT_LAST_C) begin
               state_nxt_s = ST_INIT;
            end else begin
               wait_nxt_s = wait_r + WAIT_ONE_C;
            end
         end
         default: begin
            state_nxt_s = ST_INIT;
         end
      endcase
   end

   // FSM state, lock flag, slip pulse and saturating slip counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r    <= ST_INIT;
         sh_cnt_r   <= '0;
         sh_invld_r <= '0;
         wait_r     <= '0;
         lock_r     <= 1'b0;
         bitslip_r  <= 1'b0;
         slip_cnt_r <= 16'd0;
      end else begin
         state_r    <= state_nxt_s;
         sh_cnt_r   <= sh_cnt_nxt_s;
         sh_invld_r <= sh_invld_nxt_s;
         wait_r     <= wait_nxt_s;
         lock_r     <= lock_nxt_s;
         bitslip_r  <= (state_r == ST_SLIP);
         if ((state_r == ST_SLIP) && (slip_cnt_r != 16'hFFFF)) begin
            slip_cnt_r <= slip_cnt_r + 16'd1;
         end
      end
   end

   // Hi-BER window; cleared in the same edge that drops lock so both fall together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ber_cyc_r <= '0;
         ber_inv_r <= '0;
         hi_ber_r  <= 1'b0;
      end else if (!lock_r || lock_clr_s) begin
         ber_cyc_r <= '0;
         ber_inv_r <= '0;
         hi_ber_r  <= 1'b0;
      end else if (ber_cyc_r == BER_LAST_C) begin
         ber_cyc_r <= '0;
         ber_inv_r <= '0;
         hi_ber_r  <= (ber_inv_inc_s == BER_THRESH_C);
      end else begin
         ber_cyc_r <= ber_cyc_r + BER_CYC_ONE_C;
         ber_inv_r <= ber_inv_inc_s;
         hi_ber_r  <= hi_ber_r | (ber_inv_inc_s == BER_THRESH_C);
      end
   end

   assign o_bitslip         = bitslip_r;
   assign o_block_lock      = lock_r;
   assign o_hi_ber          = hi_ber_r;
   assign o_slip_count      = slip_cnt_r;
   assign o_rx_data_valid   = i_data_valid & lock_r;
   assign o_rx_header_valid = i_header_valid & lock_r;

endmodule

// File: tb/tb_eth_rx_block_lock.sv
// Scoreboard bench for eth_rx_block_lock: stimulus queues expected output edges
// with their cycle numbers; a negedge monitor pops and compares each edge seen.
module tb_eth_rx_block_lock;

   localparam int K_LOCK = 0;
   localparam int K_BER  = 1;
   localparam int K_BS   = 2;

   typedef struct {
      int   kind;
      logic val;
      int   at;
      int   cnt;
   } ev_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [1:0]  i_header;
   logic        i_header_valid;
   logic        i_data_valid;
   logic        o_bitslip;
   logic        o_block_lock;
   logic        o_hi_ber;
   logic        o_rx_data_valid;
   logic        o_rx_header_valid;
   logic [15:0] o_slip_count;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   ev_t  exp_q[$];
   ev_t  miss_e;
   logic p_lock = 1'b0, p_ber = 1'b0, p_bs = 1'b0;
   int   r0, r2, r4, r5;

   eth_rx_block_lock #(
      .SH_CNT_MAX  (64),
      .SH_INVLD_MAX(16),
      .SLIP_WAIT   (32),
      .BER_WINDOW  (200),
      .BER_THRESH  (4)
   ) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_header         (i_header),
      .i_header_valid   (i_header_valid),
      .i_data_valid     (i_data_valid),
      .o_bitslip        (o_bitslip),
      .o_block_lock     (o_block_lock),
      .o_hi_ber         (o_hi_ber),
      .o_rx_data_valid  (o_rx_data_valid),
      .o_rx_header_valid(o_rx_header_valid),
      .o_slip_count     (o_slip_count)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input logic val, input int at, input int cnt);
      ev_t e;
      e.kind = kind; e.val = val; e.at = at; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   task automatic see(input int kind, input logic val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_edge: kind=%0d val=%0b at cycle %0d, nothing expected", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val !== val || e.at != cyc ||
             (kind == K_BS && val == 1'b1 && int'(o_slip_count) != e.cnt)) begin
            errors++;
            $display("FAIL edge: got kind=%0d val=%0b cycle=%0d slips=%0d, expected kind=%0d val=%0b cycle=%0d slips=%0d",
                     kind, val, cyc, o_slip_count, e.kind, e.val, e.at, e.cnt);
         end
      end
   endtask

   // Monitor: flags overdue expectations, then matches each observed output edge.
   always @(negedge i_clk) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         miss_e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_edge: kind=%0d val=%0b never seen, expected at cycle %0d", miss_e.kind, miss_e.val, miss_e.at);
      end
      if (o_block_lock !== p_lock) see(K_LOCK, o_block_lock);
      if (o_hi_ber !== p_ber) see(K_BER, o_hi_ber);
      if (o_bitslip !== p_bs) see(K_BS, o_bitslip);
      p_lock = o_block_lock;
      p_ber  = o_hi_ber;
      p_bs   = o_bitslip;
   end

   task automatic drive(input logic [1:0] hdr, input logic dv, input logic hv);
      i_header       = hdr;
      i_data_valid   = dv;
      i_header_valid = hv;
      @(posedge i_clk);
      #1;
   endtask

   task automatic run(input int n, input logic [1:0] hdr);
      repeat (n) drive(hdr, 1'b1, 1'b1);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_header = 2'b01;
      i_data_valid = 1'b1;
      i_header_valid = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_bitslip", o_bitslip, 0);
      check("rst_lock", o_block_lock, 0);
      check("rst_hi_ber", o_hi_ber, 0);
      check("rst_slip_count", o_slip_count, 0);
      check("rst_rx_data_valid", o_rx_data_valid, 0);
      check("rst_rx_header_valid", o_rx_header_valid, 0);

      // Clean headers: 64 samples in TEST from r0+1, lock visible r0+65.
      r0 = cyc;
      i_rst_n = 1'b1;
      expect_ev(K_LOCK, 1'b1, r0 + 65, 0);
      run(65, 2'b01);
      check("clean_slip_count", o_slip_count, 0);

      // Hi-BER: 4 invalid at r0+70..73, set r0+74; clean window ends r0+464.
      run(5, 2'b01);
      expect_ev(K_BER, 1'b1, r0 + 74, 0);
      run(4, 2'b11);
      expect_ev(K_BER, 1'b0, r0 + 465, 0);
      run(391, 2'b01);

      // 15 invalid in the window starting r0+521 keeps lock (but re-raises hi-BER).
      run(56, 2'b01);
      expect_ev(K_BER, 1'b1, r0 + 525, 0);
      run(15, 2'b11);
      run(50, 2'b01);

      // 16 invalid in the window starting r0+586: lock drops, one slip, relock.
      expect_ev(K_LOCK, 1'b0, r0 + 602, 0);
      expect_ev(K_BER, 1'b0, r0 + 602, 0);
      expect_ev(K_BS, 1'b1, r0 + 603, 1);
      expect_ev(K_BS, 1'b0, r0 + 604, 0);
      expect_ev(K_LOCK, 1'b1, r0 + 700, 0);
      run(16, 2'b11);
      run(110, 2'b01);
      check("relock_slip_count", o_slip_count, 1);

      // Asynchronous reset while locked.
      expect_ev(K_LOCK, 1'b0, cyc, 0);
      i_rst_n = 1'b0;
      #1;
      check("arst_lock", o_block_lock, 0);
      check("arst_slip_count", o_slip_count, 0);
      check("arst_rx_data_valid", o_rx_data_valid, 0);
      repeat (2) drive(2'b01, 1'b1, 1'b1);

      // 50% data valid: samples at even offsets 2..128, lock visible r2+129.
      r2 = cyc;
      i_rst_n = 1'b1;
      expect_ev(K_LOCK, 1'b1, r2 + 129, 0);
      for (int k = 0; k < 129; k++) begin
         i_header = 2'b01;
         i_data_valid = (k % 2 == 0);
         i_header_valid = 1'b1;
         #1;
         if (k == 64) check("rx_data_valid_unlocked", o_rx_data_valid, 0);
         @(posedge i_clk);
         #1;
      end
      for (int k = 129; k < 133; k++) begin
         i_data_valid = (k % 2 == 0);
         #1;
         check("rx_data_valid_locked", o_rx_data_valid, (k % 2 == 0) ? 1 : 0);
         check("rx_header_valid_locked", o_rx_header_valid, 1);
         @(posedge i_clk);
         #1;
      end

      // All-invalid headers: slips at r4+3, +38, +73; reset lands in WAIT.
      expect_ev(K_LOCK, 1'b0, cyc, 0);
      i_rst_n = 1'b0;
      repeat (2) drive(2'b11, 1'b1, 1'b1);
      r4 = cyc;
      i_rst_n = 1'b1;
      for (int p = 0; p < 3; p++) begin
         expect_ev(K_BS, 1'b1, r4 + 3 + 35 * p, p + 1);
         expect_ev(K_BS, 1'b0, r4 + 4 + 35 * p, 0);
      end
      run(80, 2'b11);
      check("slip_count_before_reset", o_slip_count, 3);
      i_rst_n = 1'b0;
      #1;
      check("wait_rst_slip_count", o_slip_count, 0);
      check("wait_rst_bitslip", o_bitslip, 0);
      check("wait_rst_lock", o_block_lock, 0);
      repeat (2) drive(2'b01, 1'b1, 1'b1);

      // Relock after reset needs the full 64 samples again.
      r5 = cyc;
      i_rst_n = 1'b1;
      expect_ev(K_LOCK, 1'b1, r5 + 65, 0);
      run(70, 2'b01);
      check("final_slip_count", o_slip_count, 0);
      check("pending_edges", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eth_rx_block_lock.md
# eth_rx_block_lock

Receive-side 64b/66b block-lock and bit-error controller for the 10GBASE-R RX path. It sits between the transceiver gearbox and the eth RX stream interface, and samples the 2-bit sync headers the gearbox presents with each block. It drives a single-cycle bitslip request back to the gearbox until header alignment is found. Once lock is declared it gates the data/header valid strobes forwarded to the RX interface and flags high bit-error rate.

## Interface
- SH_CNT_MAX, 64: headers per test window.
- SH_INVLD_MAX, 16: invalid headers per window that cause loss of lock while locked.
- SLIP_WAIT, 32: cycles the FSM ignores headers after a bitslip pulse.
- BER_WINDOW, 50000: hi-BER window length in i_clk cycles.
- BER_THRESH, 16: invalid headers per BER window that set hi-BER.
- i_clk  in  1  RX user clock.
- i_rst_n  in  1  Reset; asynchronous, active-low.
- i_header  in  2  Sync header from the gearbox.
- i_header_valid  in  1  i_header is valid this beat.
- i_data_valid  in  1  Gearbox beat valid; headers count only when i_data_valid && i_header_valid.
- o_bitslip  out  1  One-cycle slip request to the gearbox.
- o_block_lock  out  1  Block lock achieved.
- o_hi_ber  out  1  High bit-error rate detected.
- o_rx_data_valid  out  1  i_data_valid && o_block_lock (combinational).
- o_rx_header_valid  out  1  i_header_valid && o_block_lock (combinational).
- o_slip_count  out  16  Saturating count of bitslips since reset.

## Operation
- A header sample is a cycle with i_data_valid && i_header_valid. The header is valid when i_header is 2'b01 or 2'b10 and invalid when it is 2'b00 or 2'b11.
- The FSM has four states: INIT, TEST, SLIP, WAIT.
- INIT: clears sh_cnt, sh_invld_cnt and the wait counter. Goes to TEST on the next cycle.
- TEST, on each header sample:
  - sh_cnt increments; sh_invld_cnt also increments on an invalid header.
  - Unlocked, invalid header: go to SLIP.
  - Unlocked, sh_cnt reaches SH_CNT_MAX with zero invalid headers: set lock, go to INIT.
  - Locked, sh_invld_cnt reaches SH_INVLD_MAX: clear lock, go to SLIP. This check takes priority over window completion.
  - Locked, sh_cnt reaches SH_CNT_MAX with sh_invld_cnt < SH_INVLD_MAX: go to INIT; lock stays set.
- SLIP: o_bitslip=1 for exactly one cycle. o_slip_count increments and saturates at 16'hFFFF. Go to WAIT.
- WAIT: counts SLIP_WAIT i_clk cycles, independent of valid strobes. Header samples arriving in WAIT are ignored. Go to INIT when the count completes.
- Hi-BER monitor, active only while o_block_lock=1:
  - Counts i_clk cycles up to BER_WINDOW.
  - Counts invalid header samples within the window, saturating at BER_THRESH.
  - o_hi_ber sets in the cycle after the invalid count reaches BER_THRESH.
  - At the end of each window both counters clear. o_hi_ber clears if the finished window held fewer than BER_THRESH invalid headers.
- When lock is lost, the BER counters clear and o_hi_ber=0.
- Counter widths are $clog2(max+1). sh_cnt compares against SH_CNT_MAX using the post-increment value.

## Timing
- Reset values: o_bitslip=0, o_block_lock=0, o_hi_ber=0, o_slip_count=0, FSM=INIT. o_rx_data_valid and o_rx_header_valid are therefore 0 during reset.
- o_block_lock rises in the cycle after the 64th clean header sample. It falls in the cycle after the 16th invalid header sample of a window.
- o_bitslip asserts 2 cycles after the invalid header sample that triggered it (TEST→SLIP registered, then SLIP output).
- Minimum spacing between bitslip pulses: SLIP_WAIT + 3 cycles.
- If reset is asserted mid-operation, all state clears immediately and asynchronously. No slip pulse is emitted during or after reset.
- Header samples that arrive while the FSM is in INIT are ignored.

## Test plan
- All headers 2'b01 from reset → o_block_lock=1 after 64 samples plus 2 cycles; o_bitslip never asserts; o_slip_count=0.
- Headers 2'b11 from reset → bitslip pulses 1 cycle wide, spaced exactly SLIP_WAIT+3 cycles; o_slip_count increments per pulse.
- Locked, then 15 invalid headers in a 64-sample window → lock held. Then 16 invalid headers in the next window → o_block_lock falls and one bitslip follows.
- Locked with BER_WINDOW=200 and BER_THRESH=4: inject 4 invalid headers in a window → o_hi_ber=1. A clean window follows → o_hi_ber=0 at window end.
- Toggle i_data_valid at 50% with valid headers → lock still requires 64 qualified samples; o_rx_data_valid tracks i_data_valid after lock.
- Assert i_rst_n low during WAIT and while locked → all outputs return to 0 asynchronously; relock takes the full 64 samples.
